// File: rtl/udp_pic_wr_ctrl.sv
// udp_pic_wr_ctrl
// Receive-side write controller for the ping-pong picture frame buffer (mac_rx_clk domain).
// Parses UDP image-line packets:
//   MAGIC hi, MAGIC lo, line hi, line lo, then 2*H_ACTIVE pixel bytes.
// Pixel bytes are packed into RGB565 words, each written to line*H_ACTIVE + col.
// The written bank toggles with frame_done once the last word of line V_ACTIVE-1 is written.
// Malformed or truncated packets are dropped and flagged with pkt_err.
// Optional feature macro: PIC_WR_STAT_EN adds saturating frame_cnt / err_cnt outputs.
module udp_pic_wr_ctrl #(
  parameter int          H_ACTIVE = 640,
  parameter int          V_ACTIVE = 480,
  parameter int          ADDR_W   = 19,
  parameter logic [15:0] MAGIC    = 16'hA55A
) (
  input  logic              mac_rx_clk,
  input  logic              rst,
  input  logic [7:0]        udp_rx_data,
  input  logic              udp_rx_en,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic              wr_bank,
  output logic              frame_start,
  output logic              frame_done,
  output logic              pkt_err
`ifdef PIC_WR_STAT_EN
  ,
  output logic [15:0]       frame_cnt,
  output logic [15:0]       err_cnt
`endif
);

  localparam int COL_W = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_PIX,
    S_TAIL,
    S_DROP
  } state_t;

  state_t            state_q,       state_d;
  logic [1:0]        hdr_cnt_q,     hdr_cnt_d;
  logic [7:0]        line_hi_q,     line_hi_d;
  logic [ADDR_W-1:0] base_q,        base_d;
  logic              last_line_q,   last_line_d;
  logic [COL_W-1:0]  col_q,         col_d;
  logic [7:0]        hi_byte_q,     hi_byte_d;
  logic              odd_q,         odd_d;
  logic              done_pend_q,   done_pend_d;
  logic              wr_en_q,       wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q,     wr_addr_d;
  logic [15:0]       wr_data_q,     wr_data_d;
  logic              wr_bank_q,     wr_bank_d;
  logic              frame_start_q, frame_start_d;
  logic              frame_done_q,  frame_done_d;
  logic              pkt_err_q,     pkt_err_d;

  logic [15:0]       line_full;

  assign line_full = {line_hi_q, udp_rx_data};

  // Next-state and registered-output computation for the packet parser.
  always_comb begin
    // NOTE: every _d gets a default first so no path can infer a latch.
    state_d       = state_q;
    hdr_cnt_d     = hdr_cnt_q;
    line_hi_d     = line_hi_q;
    base_d        = base_q;
    last_line_d   = last_line_q;
    col_d         = col_q;
    hi_byte_d     = hi_byte_q;
    odd_d         = odd_q;
    done_pend_d   = 1'b0;
    wr_en_d       = 1'b0;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    wr_bank_d     = wr_bank_q;
    frame_start_d = 1'b0;
    frame_done_d  = 1'b0;
    pkt_err_d     = 1'b0;

    // Frame completion lands one cycle after the final write of the last line.
    if (done_pend_q) begin
      frame_done_d = 1'b1;
      wr_bank_d    = ~wr_bank_q;
    end

    case (state_q)
      S_IDLE: begin
        if (udp_rx_en) begin
          if (udp_rx_data == MAGIC[15:8]) begin
            state_d   = S_HDR;
            hdr_cnt_d = 2'd1;
          end else begin
            state_d   = S_DROP;
            pkt_err_d = 1'b1;
          end
        end
      end

      S_HDR: begin
        if (!udp_rx_en) begin
          state_d   = S_IDLE;
          pkt_err_d = 1'b1;
        end else begin
          case (hdr_cnt_q)
            2'd1: begin
              if (udp_rx_data != MAGIC[7:0]) begin
                state_d   = S_DROP;
                pkt_err_d = 1'b1;
              end else begin
                hdr_cnt_d = 2'd2;
              end
            end
            2'd2: begin
              line_hi_d = udp_rx_data;
              hdr_cnt_d = 2'd3;
            end
            default: begin
              if (32'(line_full) >= 32'(V_ACTIVE)) begin
                state_d   = S_DROP;
                pkt_err_d = 1'b1;
              end else begin
                state_d       = S_PIX;
                col_d         = '0;
                odd_d         = 1'b0;
                // Line base is computed once here so the pixel path only needs an adder.
                base_d        = ADDR_W'(int'(line_full) * H_ACTIVE);
                last_line_d   = (32'(line_full) == 32'(V_ACTIVE - 1));
                frame_start_d = (line_full == 16'd0);
              end
            end
          endcase
        end
      end

      S_PIX: begin
        if (!udp_rx_en) begin
          // Truncated line: earlier words stay written, a dangling high byte is dropped.
          state_d   = S_IDLE;
          pkt_err_d = 1'b1;
        end else if (!odd_q) begin
          hi_byte_d = udp_rx_data;
          odd_d     = 1'b1;
        end else begin
          odd_d     = 1'b0;
          wr_en_d   = 1'b1;
          wr_data_d = {hi_byte_q, udp_rx_data};
          wr_addr_d = base_q + ADDR_W'(col_q);
          if (col_q == COL_W'(H_ACTIVE - 1)) begin
            state_d     = S_TAIL;
            done_pend_d = last_line_q;
          end else begin
            col_d = col_q + COL_W'(1);
          end
        end
      end

      S_TAIL: begin
        if (!udp_rx_en) state_d = S_IDLE;
      end

      S_DROP: begin
        if (!udp_rx_en) state_d = S_IDLE;
      end

      default: state_d = S_DROP;
    endcase
  end

  // State and output registers with synchronous reset; reset parks in DROP so a
  // packet already in flight is skipped until udp_rx_en is seen low.
  always_ff @(posedge mac_rx_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q       <= S_DROP;
      hdr_cnt_q     <= 2'd0;
      line_hi_q     <= 8'd0;
      base_q        <= '0;
      last_line_q   <= 1'b0;
      col_q         <= '0;
      hi_byte_q     <= 8'd0;
      odd_q         <= 1'b0;
      done_pend_q   <= 1'b0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= 16'd0;
      wr_bank_q     <= 1'b0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      pkt_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      hdr_cnt_q     <= hdr_cnt_d;
      line_hi_q     <= line_hi_d;
      base_q        <= base_d;
      last_line_q   <= last_line_d;
      col_q         <= col_d;
      hi_byte_q     <= hi_byte_d;
      odd_q         <= odd_d;
      done_pend_q   <= done_pend_d;
      wr_en_q       <= wr_en_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      wr_bank_q     <= wr_bank_d;
      frame_start_q <= frame_start_d;
      frame_done_q  <= frame_done_d;
      pkt_err_q     <= pkt_err_d;
    end
  end

  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign wr_bank     = wr_bank_q;
  assign frame_start = frame_start_q;
  assign frame_done  = frame_done_q;
  assign pkt_err     = pkt_err_q;

`ifdef PIC_WR_STAT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [15:0] err_cnt_q,   err_cnt_d;

  // Saturating counters, stepped in the same cycle as the pulse they count.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    err_cnt_d   = err_cnt_q;
    if (frame_done_d && (frame_cnt_q != 16'hFFFF)) frame_cnt_d = frame_cnt_q + 16'd1;
    if (pkt_err_d && (err_cnt_q != 16'hFFFF))      err_cnt_d   = err_cnt_q + 16'd1;
  end

  // Statistics registers, cleared by reset.
  always_ff @(posedge mac_rx_clk) begin
    if (rst) begin
      frame_cnt_q <= 16'd0;
      err_cnt_q   <= 16'd0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign err_cnt   = err_cnt_q;
`endif

endmodule
